// File: rtl/ysyx_22050550_mem_arbiter.sv
// IFU/LSU arbiter for the shared cache/memory port: latches one request, runs the
// valid/ready handshake downstream, and returns the response as a one-cycle done pulse.
module ysyx_22050550_mem_arbiter #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_LSU_RUN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_valid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_done,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_LSU_RUN);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [3:0]          lsu_run_q, lsu_run_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;
    logic                lsu_grant;
    logic                complete;

    // LSU wins unless IFU is waiting and the LSU run has reached its limit
    assign lsu_grant = lsu_valid && (!ifu_valid || (lsu_run_q < MAX_RUN));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lsu_run_d = lsu_run_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        complete  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lsu_grant) begin
                    state_d   = ST_REQ;
                    owner_d   = OWN_LSU;
                    lsu_run_d = ifu_valid ? ((lsu_run_q < MAX_RUN) ? lsu_run_q + 4'd1 : lsu_run_q)
                                          : 4'd0;
                    addr_d    = lsu_addr;
                    wen_d     = lsu_wen;
                    wdata_d   = lsu_wdata;
                    wmask_d   = lsu_wmask;
                end else if (ifu_valid) begin
                    state_d   = ST_REQ;
                    owner_d   = OWN_IFU;
                    lsu_run_d = 4'd0;
                    addr_d    = ifu_addr;
                    wen_d     = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = 8'h00;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                        owner_d  = OWN_NONE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    owner_d  = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            lsu_run_q <= 4'd0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lsu_run_q <= lsu_run_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    // A completion during a reset cycle is abandoned, so done is masked by reset
    assign ifu_done  = complete && (owner_q == OWN_IFU) && reset;
    assign lsu_done  = complete && (owner_q == OWN_LSU) && reset;
    assign ifu_rdata = ifu_done ? mem_rdata : '0;
    assign lsu_rdata = lsu_done ? mem_rdata : '0;

    assign mem_valid = (state_q == ST_REQ);
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_22050550_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a per-cycle vector table followed by
// hand-written sequences for starvation, back-pressure and reset-during-response.
module tb_ysyx_22050550_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_valid;
    logic [63:0] ifu_addr;
    logic        ifu_done;
    logic [63:0] ifu_rdata;
    logic        lsu_valid;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_done;
    logic [63:0] lsu_rdata;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int assertCount;
    int failCount;

    localparam logic [63:0] IA0 = 64'h8000_0000;
    localparam logic [63:0] IA1 = 64'h8000_0004;
    localparam logic [63:0] LA  = 64'h8000_1000;
    localparam logic [63:0] WD  = 64'h0000_dead;
    localparam logic [7:0]  WM  = 8'h0f;

    ysyx_22050550_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LSU_RUN(4)) dut (
        .clock(clock), .reset(reset),
        .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_rdata(ifu_rdata),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [63:0] ia;
        logic        lv;
        logic [63:0] la;
        logic        lw;
        logic [63:0] lwd;
        logic [7:0]  lm;
        logic        rdy;
        logic        rv;
        logic [63:0] rd;
        logic        eMv;
        logic [63:0] eMa;
        logic        eMw;
        logic [63:0] eMwd;
        logic [7:0]  eMm;
        logic        eId;
        logic [63:0] eIrd;
        logic        eLd;
        logic [63:0] eLrd;
    } vec_t;

    vec_t vecs[12];

    // Drives one cycle's worth of inputs
    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        ifu_valid  = v.iv;
        ifu_addr   = v.ia;
        lsu_valid  = v.lv;
        lsu_addr   = v.la;
        lsu_wen    = v.lw;
        lsu_wdata  = v.lwd;
        lsu_wmask  = v.lm;
        mem_ready  = v.rdy;
        mem_rvalid = v.rv;
        mem_rdata  = v.rd;
    endtask

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".mem_valid"}, 64'(mem_valid), 64'(v.eMv));
        checkOutput({v.name, ".mem_addr"},  mem_addr,        v.eMa);
        checkOutput({v.name, ".mem_wen"},   64'(mem_wen),   64'(v.eMw));
        checkOutput({v.name, ".mem_wdata"}, mem_wdata,       v.eMwd);
        checkOutput({v.name, ".mem_wmask"}, 64'(mem_wmask), 64'(v.eMm));
        checkOutput({v.name, ".ifu_done"},  64'(ifu_done),  64'(v.eId));
        checkOutput({v.name, ".ifu_rdata"}, ifu_rdata,       v.eIrd);
        checkOutput({v.name, ".lsu_done"},  64'(lsu_done),  64'(v.eLd));
        checkOutput({v.name, ".lsu_rdata"}, lsu_rdata,       v.eLrd);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut();
        reset      = 1'b0;
        ifu_valid  = 1'b0;
        lsu_valid  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
    endtask

    string expOrder;
    string gotOrder;

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Row timeline: reset held with both requesters active, LSU wins on release,
        // IFU follows after the idle cycle, then a plain IFU fetch with a RESP wait.
        vecs[0]  = '{"rst_hold",  1'b0, 1'b1, IA1, 1'b1, LA, 1'b1, WD, WM, 1'b1, 1'b1, 64'h55,
                     1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{"rel_idle",  1'b1, 1'b1, IA1, 1'b1, LA, 1'b1, WD, WM, 1'b0, 1'b0, 64'h0,
                     1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[2]  = '{"lsu_req",   1'b1, 1'b1, IA1, 1'b1, LA, 1'b1, WD, WM, 1'b1, 1'b0, 64'h0,
                     1'b1, LA, 1'b1, WD, WM, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[3]  = '{"lsu_resp",  1'b1, 1'b1, IA1, 1'b1, LA, 1'b1, WD, WM, 1'b0, 1'b1, 64'h1111,
                     1'b0, LA, 1'b1, WD, WM, 1'b0, 64'h0, 1'b1, 64'h1111};
        vecs[4]  = '{"ifu_grant", 1'b1, 1'b1, IA1, 1'b0, LA, 1'b1, WD, WM, 1'b0, 1'b0, 64'h0,
                     1'b0, LA, 1'b1, WD, WM, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[5]  = '{"ifu_fast",  1'b1, 1'b1, IA1, 1'b0, LA, 1'b1, WD, WM, 1'b1, 1'b1, 64'h13,
                     1'b1, IA1, 1'b0, 64'h0, 8'h00, 1'b1, 64'h13, 1'b0, 64'h0};
        vecs[6]  = '{"stray_rv",  1'b1, 1'b0, IA1, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h99,
                     1'b0, IA1, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[7]  = '{"ifu_c0",    1'b1, 1'b1, IA0, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                     1'b0, IA1, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[8]  = '{"ifu_c1",    1'b1, 1'b1, IA0, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                     1'b1, IA0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[9]  = '{"ifu_c2",    1'b1, 1'b1, IA0, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                     1'b0, IA0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[10] = '{"ifu_c3",    1'b1, 1'b1, IA0, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h13,
                     1'b0, IA0, 1'b0, 64'h0, 8'h00, 1'b1, 64'h13, 1'b0, 64'h0};
        vecs[11] = '{"ifu_after", 1'b1, 1'b0, IA0, 1'b0, LA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                     1'b0, IA0, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0};

        // First reset cycle is unchecked since the state is unknown before the first edge
        applyStimulus(vecs[0]);
        nextCycle();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkVector(vecs[i]);
            nextCycle();
        end

        // Starvation guard: four LSU grants while IFU waits, then IFU, repeating
        $display("[TB] starvation sequence");
        resetDut();
        lsu_valid = 1'b1;
        lsu_addr  = LA + 64'h10;
        lsu_wen   = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = 8'h00;
        ifu_valid = 1'b1;
        ifu_addr  = IA0;
        expOrder  = "LLLLILLLLI";
        gotOrder  = "";
        for (int cyc = 0; cyc < 40 && gotOrder.len() < 10; cyc++) begin
            mem_ready  = mem_valid;
            mem_rvalid = mem_valid;
            mem_rdata  = 64'(cyc);
            @(negedge clock);
            if (ifu_done && lsu_done) checkOutput("starve_both_done", 64'd1, 64'd0);
            if (lsu_done) gotOrder = {gotOrder, "L"};
            if (ifu_done) gotOrder = {gotOrder, "I"};
            nextCycle();
        end
        checkOutput("starve_count", 64'(gotOrder.len()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < gotOrder.len())
                checkOutput($sformatf("starve_order[%0d]", k), 64'(gotOrder[k]), 64'(expOrder[k]));
            else
                checkOutput($sformatf("starve_order[%0d]", k), 64'h0, 64'(expOrder[k]));
        end
        ifu_valid = 1'b0;
        lsu_valid = 1'b0;

        // Back-pressure: REQ held for five cycles, stray rvalid ignored, then single-cycle finish
        $display("[TB] back-pressure sequence");
        resetDut();
        lsu_valid  = 1'b1;
        lsu_addr   = LA + 64'h8;
        lsu_wen    = 1'b1;
        lsu_wdata  = 64'hcafe;
        lsu_wmask  = 8'hf0;
        @(negedge clock);
        checkOutput("bp_idle.mem_valid", 64'(mem_valid), 64'd0);
        nextCycle();
        for (int k = 0; k < 5; k++) begin
            mem_ready  = 1'b0;
            mem_rvalid = k[0];
            mem_rdata  = 64'hbad;
            @(negedge clock);
            checkOutput($sformatf("bp_hold%0d.mem_valid", k), 64'(mem_valid), 64'd1);
            checkOutput($sformatf("bp_hold%0d.mem_addr", k), mem_addr, LA + 64'h8);
            checkOutput($sformatf("bp_hold%0d.lsu_done", k), 64'(lsu_done), 64'd0);
            nextCycle();
        end
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h77;
        @(negedge clock);
        checkOutput("bp_fin.mem_wdata", mem_wdata, 64'hcafe);
        checkOutput("bp_fin.mem_wmask", 64'(mem_wmask), 64'hf0);
        checkOutput("bp_fin.lsu_done", 64'(lsu_done), 64'd1);
        checkOutput("bp_fin.lsu_rdata", lsu_rdata, 64'h77);
        nextCycle();
        lsu_valid  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h88;
        @(negedge clock);
        checkOutput("bp_post.mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("bp_post.lsu_done", 64'(lsu_done), 64'd0);
        checkOutput("bp_post.lsu_rdata", lsu_rdata, 64'h0);
        nextCycle();

        // Reset while waiting in RESP abandons the fetch without a done pulse
        $display("[TB] reset-in-resp sequence");
        resetDut();
        ifu_valid  = 1'b1;
        ifu_addr   = IA0;
        nextCycle();
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        @(negedge clock);
        checkOutput("rr_req.mem_valid", 64'(mem_valid), 64'd1);
        nextCycle();
        mem_ready  = 1'b0;
        @(negedge clock);
        checkOutput("rr_resp.mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("rr_resp.ifu_done", 64'(ifu_done), 64'd0);
        nextCycle();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h42;
        @(negedge clock);
        checkOutput("rr_rst.ifu_done", 64'(ifu_done), 64'd0);
        checkOutput("rr_rst.ifu_rdata", ifu_rdata, 64'h0);
        nextCycle();
        reset     = 1'b1;
        ifu_valid = 1'b0;
        @(negedge clock);
        checkOutput("rr_after.ifu_done", 64'(ifu_done), 64'd0);
        checkOutput("rr_after.mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("rr_after.mem_addr", mem_addr, 64'h0);
        nextCycle();
        @(negedge clock);
        checkOutput("rr_stray.ifu_done", 64'(ifu_done), 64'd0);
        checkOutput("rr_stray.lsu_done", 64'(lsu_done), 64'd0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
